// File: rtl/auth_lut_arbiter_if.sv
// auth_lut_arbiter_if: one requester channel of the auth LUT arbiter.
//   master : requester side (drives valid/cmd/uid/len, receives ready/rsp_*)
//   slave  : arbiter side
// Signals:
//   valid/ready  command handshake, transfer on valid & ready
//   cmd          command byte (0x10 check, 0x11 add)
//   uid, len     UID bytes (byte i at [i*8 +: 8]) and length in bytes
//   rsp_valid    one-cycle response strobe
//   rsp_code     status code, held between strobes
interface auth_lut_arbiter_if #(
  parameter int unsigned UID_BYTES = 16
) ();
  localparam int unsigned UidW = 8 * UID_BYTES;

  logic            valid;
  logic            ready;
  logic [7:0]      cmd;
  logic [UidW-1:0] uid;
  logic [7:0]      len;
  logic            rsp_valid;
  logic [7:0]      rsp_code;

  modport master (output valid, cmd, uid, len, input ready, rsp_valid, rsp_code);
  modport slave  (input valid, cmd, uid, len, output ready, rsp_valid, rsp_code);
endinterface

// File: rtl/auth_lut_arbiter.sv
// auth_lut_arbiter: shares one auth_lut between the host frame parser (req0)
// and the RFID reader front end (req1). Round-robin, one command in flight.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req0, req1          requester channels (auth_lut_arbiter_if.slave)
//   busy                high whenever not idle
//   lut_cmd/lut_valid/lut_uid_flat/lut_uid_len   LUT request
//   lut_allowed/lut_added_ok/lut_duplicate/lut_full  LUT result flags
// Option: AUTH_LUT_ARB_READER_WRITE_LOCK_EN rejects add commands from req1.
module auth_lut_arbiter #(
  parameter int unsigned UID_BYTES   = 16,
  parameter int unsigned LUT_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  auth_lut_arbiter_if.slave        req0,
  auth_lut_arbiter_if.slave        req1,
  output logic                     busy,
  output logic [7:0]               lut_cmd,
  output logic                     lut_valid,
  output logic [8*UID_BYTES-1:0]   lut_uid_flat,
  output logic [7:0]               lut_uid_len,
  input  logic                     lut_allowed,
  input  logic                     lut_added_ok,
  input  logic                     lut_duplicate,
  input  logic                     lut_full
);
  localparam int unsigned UidW = 8 * UID_BYTES;
  localparam int unsigned CntW = $clog2(LUT_LATENCY) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [7:0] CMD_CHECK = 8'h10;
  localparam logic [7:0] CMD_ADD   = 8'h11;
  localparam logic [7:0] CODE_ERR  = 8'hEF;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            r_last;
  logic            r_gnt;
  logic [CntW-1:0] r_cnt;
  logic            r_busy;
  logic            r_lut_valid;
  logic [7:0]      r_lut_cmd;
  logic [UidW-1:0] r_lut_uid;
  logic [7:0]      r_lut_len;
  logic            r_rsp0_valid;
  logic            r_rsp1_valid;
  logic [7:0]      r_rsp0_code;
  logic [7:0]      r_rsp1_code;

  logic            w_gnt;
  logic            w_req_valid;
  logic [7:0]      w_req_cmd;
  logic [7:0]      w_req_len;
  logic [UidW-1:0] w_req_uid;
  logic            w_lock;
  logic            w_reject;
  logic            w_accept;
  logic            w_cnt_last;
  logic            w_rsp_port;
  logic [7:0]      w_code;
  logic            w_unused;

  // A full table has no dedicated code; it falls into the generic failure.
  assign w_unused = lut_full;

`ifdef AUTH_LUT_ARB_READER_WRITE_LOCK_EN
  // The reader may only query the table, never write it.
  assign w_lock = w_gnt & (w_req_cmd == CMD_ADD);
`else
  assign w_lock = 1'b0;
`endif

  assign w_cnt_last = (r_cnt == CntW'(LUT_LATENCY - 1));
  assign w_accept   = (r_state == S_IDLE) & w_req_valid;

  assign req0.ready = (r_state == S_IDLE) & ~w_gnt & req0.valid;
  assign req1.ready = (r_state == S_IDLE) &  w_gnt & req1.valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Grant selection, reject decode, next state and response code.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 1'b0;
    w_req_valid = 1'b0;
    w_req_cmd   = 8'h00;
    w_req_len   = 8'h00;
    w_req_uid   = '0;
    w_reject    = 1'b0;
    w_rsp_port  = r_gnt;
    w_code      = CODE_ERR;

    // On a tie the port not served last time wins.
    if (req0.valid && req1.valid) w_gnt = ~r_last;
    else                          w_gnt = req1.valid;

    if (w_gnt) begin
      w_req_valid = req1.valid;
      w_req_cmd   = req1.cmd;
      w_req_len   = req1.len;
      w_req_uid   = req1.uid;
    end else begin
      w_req_valid = req0.valid;
      w_req_cmd   = req0.cmd;
      w_req_len   = req0.len;
      w_req_uid   = req0.uid;
    end

    w_reject = ((w_req_cmd != CMD_CHECK) && (w_req_cmd != CMD_ADD)) ||
               (w_req_len > 8'(UID_BYTES)) || w_lock;

    case (r_state)
      S_IDLE: begin
        w_rsp_port = w_gnt;
        if (w_req_valid) w_state_nxt = w_reject ? S_RESP : S_ISSUE;
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_cnt_last) w_state_nxt = S_RESP;
        if (r_lut_cmd == CMD_CHECK) w_code = lut_allowed ? 8'h01 : 8'h00;
        else if (lut_added_ok)      w_code = 8'h02;
        else if (lut_duplicate)     w_code = 8'hEE;
        else                        w_code = CODE_ERR;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Transaction context, LUT drive and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last       <= 1'b1;
      r_gnt        <= 1'b0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_lut_valid  <= 1'b0;
      r_lut_cmd    <= 8'h00;
      r_lut_uid    <= '0;
      r_lut_len    <= 8'h00;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_code  <= 8'h00;
      r_rsp1_code  <= 8'h00;
    end else begin
      r_busy       <= (w_state_nxt != S_IDLE);
      r_lut_valid  <= (w_state_nxt == S_ISSUE);
      r_rsp0_valid <= (w_state_nxt == S_RESP) & ~w_rsp_port;
      r_rsp1_valid <= (w_state_nxt == S_RESP) &  w_rsp_port;

      if (w_accept) r_gnt <= w_gnt;

      if (w_accept && !w_reject) begin
        r_lut_cmd <= w_req_cmd;
        r_lut_uid <= w_req_uid;
        r_lut_len <= w_req_len;
      end

      if (r_state == S_WAIT) r_cnt <= r_cnt + CntW'(1);
      else                   r_cnt <= '0;

      if (w_state_nxt == S_RESP && r_state != S_RESP) begin
        if (w_rsp_port) r_rsp1_code <= w_code;
        else            r_rsp0_code <= w_code;
      end

      if (r_state == S_RESP) r_last <= r_gnt;
    end
  end

  assign busy           = r_busy;
  assign lut_valid      = r_lut_valid;
  assign lut_cmd        = r_lut_cmd;
  assign lut_uid_flat   = r_lut_uid;
  assign lut_uid_len    = r_lut_len;
  assign req0.rsp_valid = r_rsp0_valid;
  assign req1.rsp_valid = r_rsp1_valid;
  assign req0.rsp_code  = r_rsp0_code;
  assign req1.rsp_code  = r_rsp1_code;
endmodule

// File: tb/tb_auth_lut_arbiter.sv
// Directed bench for auth_lut_arbiter (default latency 2, 16-byte UIDs).
module tb_auth_lut_arbiter;
  localparam int unsigned UB  = 16;
  localparam int unsigned LAT = 2;

  logic clk;
  logic rst_n;
  logic busy;
  logic [7:0] lut_cmd;
  logic lut_valid;
  logic [8*UB-1:0] lut_uid_flat;
  logic [7:0] lut_uid_len;
  logic lut_allowed, lut_added_ok, lut_duplicate, lut_full;

  int n_total = 0;
  int n_bad   = 0;
  int lut_pulses = 0;
  int lut_b2b    = 0;
  int rsp_pulses = 0;
  logic prev_lut_valid = 1'b0;

  auth_lut_arbiter_if #(.UID_BYTES(UB)) req0_if ();
  auth_lut_arbiter_if #(.UID_BYTES(UB)) req1_if ();

  auth_lut_arbiter #(.UID_BYTES(UB), .LUT_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0         (req0_if),
    .req1         (req1_if),
    .busy         (busy),
    .lut_cmd      (lut_cmd),
    .lut_valid    (lut_valid),
    .lut_uid_flat (lut_uid_flat),
    .lut_uid_len  (lut_uid_len),
    .lut_allowed  (lut_allowed),
    .lut_added_ok (lut_added_ok),
    .lut_duplicate(lut_duplicate),
    .lut_full     (lut_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (lut_valid) lut_pulses <= lut_pulses + 1;
    if (lut_valid && prev_lut_valid) lut_b2b <= lut_b2b + 1;
    prev_lut_valid <= lut_valid;
    if (req0_if.rsp_valid || req1_if.rsp_valid) rsp_pulses <= rsp_pulses + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic [7:0] cmd,
                       input logic [7:0] len, input logic [127:0] uid);
    if (p == 0) begin
      req0_if.valid = v; req0_if.cmd = cmd; req0_if.len = len; req0_if.uid = uid;
    end else begin
      req1_if.valid = v; req1_if.cmd = cmd; req1_if.len = len; req1_if.uid = uid;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_if.ready : req1_if.ready;
  endfunction

  function automatic logic rspv(input int p);
    return (p == 0) ? req0_if.rsp_valid : req1_if.rsp_valid;
  endfunction

  function automatic logic [7:0] rspc(input int p);
    return (p == 0) ? req0_if.rsp_code : req1_if.rsp_code;
  endfunction

  task automatic set_flags(input logic al, input logic ad, input logic du, input logic fu);
    lut_allowed = al; lut_added_ok = ad; lut_duplicate = du; lut_full = fu;
  endtask

  // Single transaction on an idle arbiter; accept is cycle 0.
  task automatic txn(input string name, input int p, input logic [7:0] cmd,
                     input logic [7:0] len, input logic [127:0] uid,
                     input logic rej, input logic [7:0] exp_code);
    int lp0;
    lp0 = lut_pulses;
    drive(p, 1'b1, cmd, len, uid);
    #1;
    chk({name, " ready"}, 128'(rdy(p)), 128'(1));
    tick();
    drive(p, 1'b0, 8'h00, 8'h00, 128'h0);
    if (rej) begin
      chk({name, " rej rsp_valid c1"}, 128'(rspv(p)), 128'(1));
      chk({name, " rej code"}, 128'(rspc(p)), 128'(exp_code));
      chk({name, " rej lut_valid"}, 128'(lut_valid), 128'(0));
      tick();
    end else begin
      chk({name, " lut_valid c1"}, 128'(lut_valid), 128'(1));
      chk({name, " lut_cmd"}, 128'(lut_cmd), 128'(cmd));
      chk({name, " lut_len"}, 128'(lut_uid_len), 128'(len));
      chk({name, " lut_uid"}, lut_uid_flat, uid);
      tick();
      chk({name, " lut_valid c2"}, 128'(lut_valid), 128'(0));
      for (int c = 2; c < 2 + LAT; c++) begin
        chk({name, " early rsp"}, 128'(rspv(p)), 128'(0));
        tick();
      end
      chk({name, " rsp_valid"}, 128'(rspv(p)), 128'(1));
      chk({name, " code"}, 128'(rspc(p)), 128'(exp_code));
      chk({name, " other rsp"}, 128'(rspv(1 - p)), 128'(0));
      tick();
    end
    chk({name, " rsp drop"}, 128'(rspv(p)), 128'(0));
    chk({name, " idle"}, 128'(busy), 128'(0));
    chk({name, " code hold"}, 128'(rspc(p)), 128'(exp_code));
    chk({name, " lut pulses"}, 128'(lut_pulses - lp0), 128'(rej ? 0 : 1));
  endtask

  // Both ports request together; 'first' is the port expected to win.
  task automatic tie(input string name, input int first);
    int oth;
    logic [7:0] lf, lo;
    oth = 1 - first;
    lf = (first == 0) ? 8'd2 : 8'd3;
    lo = (first == 0) ? 8'd3 : 8'd2;
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, 8'h10, 8'd2, 128'hA1A2);
    drive(1, 1'b1, 8'h10, 8'd3, 128'hB1B2B3);
    #1;
    chk({name, " first ready"}, 128'(rdy(first)), 128'(1));
    chk({name, " other held"}, 128'(rdy(oth)), 128'(0));
    tick();
    drive(first, 1'b0, 8'h00, 8'h00, 128'h0);
    chk({name, " first lut_len"}, 128'(lut_uid_len), 128'(lf));
    for (int c = 1; c < 2 + LAT; c++) begin
      chk({name, " other held wait"}, 128'(rdy(oth)), 128'(0));
      tick();
    end
    chk({name, " first rsp"}, 128'(rspv(first)), 128'(1));
    chk({name, " first code"}, 128'(rspc(first)), 128'(8'h01));
    chk({name, " other held resp"}, 128'(rdy(oth)), 128'(0));
    tick();
    chk({name, " other ready"}, 128'(rdy(oth)), 128'(1));
    tick();
    drive(oth, 1'b0, 8'h00, 8'h00, 128'h0);
    chk({name, " other lut_valid"}, 128'(lut_valid), 128'(1));
    chk({name, " other lut_len"}, 128'(lut_uid_len), 128'(lo));
    for (int c = 1; c < 2 + LAT; c++) tick();
    chk({name, " other rsp"}, 128'(rspv(oth)), 128'(1));
    chk({name, " first quiet"}, 128'(rspv(first)), 128'(0));
    tick();
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, " ready0"}, 128'(req0_if.ready), 128'(0));
    chk({name, " ready1"}, 128'(req1_if.ready), 128'(0));
    chk({name, " rsp0"}, 128'(req0_if.rsp_valid), 128'(0));
    chk({name, " rsp1"}, 128'(req1_if.rsp_valid), 128'(0));
    chk({name, " code0"}, 128'(req0_if.rsp_code), 128'(0));
    chk({name, " code1"}, 128'(req1_if.rsp_code), 128'(0));
    chk({name, " busy"}, 128'(busy), 128'(0));
    chk({name, " lut_valid"}, 128'(lut_valid), 128'(0));
    chk({name, " lut_cmd"}, 128'(lut_cmd), 128'(0));
    chk({name, " lut_uid"}, lut_uid_flat, 128'(0));
    chk({name, " lut_len"}, 128'(lut_uid_len), 128'(0));
  endtask

  initial begin
    int rp0;
    rst_n = 1'b0;
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b0, 8'h00, 8'h00, 128'h0);
    drive(1, 1'b0, 8'h00, 8'h00, 128'h0);
    tick();
    tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    txn("chk_allow", 0, 8'h10, 8'd4, 128'hDEADBEEF, 1'b0, 8'h01);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    txn("chk_deny", 0, 8'h10, 8'd16, 128'h0102030405060708090A0B0C0D0E0F10, 1'b0, 8'h00);

`ifdef AUTH_LUT_ARB_READER_WRITE_LOCK_EN
    set_flags(1'b0, 1'b1, 1'b0, 1'b0);
    txn("lock_add1", 1, 8'h11, 8'd4, 128'h11223344, 1'b1, 8'hEF);
    txn("lock_add0", 0, 8'h11, 8'd4, 128'h11223344, 1'b0, 8'h02);
`else
    set_flags(1'b0, 1'b1, 1'b0, 1'b0);
    txn("add_ok", 1, 8'h11, 8'd4, 128'h11223344, 1'b0, 8'h02);
    set_flags(1'b0, 1'b0, 1'b1, 1'b0);
    txn("add_dup", 1, 8'h11, 8'd4, 128'h11223344, 1'b0, 8'hEE);
    set_flags(1'b0, 1'b0, 1'b0, 1'b1);
    txn("add_full", 1, 8'h11, 8'd4, 128'h11223344, 1'b0, 8'hEF);
`endif

    set_flags(1'b1, 1'b1, 1'b0, 1'b0);
    txn("rej_cmd", 0, 8'h22, 8'd4, 128'h55, 1'b1, 8'hEF);
    txn("rej_len", 1, 8'h10, 8'd17, 128'h66, 1'b1, 8'hEF);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tie("tie1", 0);
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    txn("solo0", 0, 8'h10, 8'd1, 128'h77, 1'b0, 8'h01);
    tie("tie2", 1);

    // Reset while the LUT strobe is high: strobe must drop without a clock.
    drive(0, 1'b1, 8'h10, 8'd4, 128'hCAFE);
    tick();
    drive(0, 1'b0, 8'h00, 8'h00, 128'h0);
    chk("issue lut_valid", 128'(lut_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("async lut_valid drop", 128'(lut_valid), 128'(0));
    chk("async busy drop", 128'(busy), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Reset during WAIT: no response may escape.
    drive(0, 1'b1, 8'h10, 8'd4, 128'hBEEF);
    tick();
    drive(0, 1'b0, 8'h00, 8'h00, 128'h0);
    tick();
    chk("wait busy", 128'(busy), 128'(1));
    rp0 = rsp_pulses;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("wait_rst");
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("no rsp after abort", 128'(rsp_pulses - rp0), 128'(0));
    tie("tie_after_rst", 0);

    chk("lut_valid back to back", 128'(lut_b2b), 128'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
